// File: rtl/clk_divider_prog.sv
// Programmable integer clock divider.
// Produces a registered divided clock (high ceil(N/2), low floor(N/2) cycles) and a
// one-cycle tick at the start of every period. A new divisor is held pending and only
// takes effect at a period boundary, so clk_div never produces a runt pulse.
module clk_divider_prog #(
  parameter int W           = 8,
  parameter int DEFAULT_DIV = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         div_load,
  input  logic [W-1:0] div_val,
  output logic         clk_div,
  output logic         tick,
  output logic         div_pending,
  output logic         div_err,
  output logic [W-1:0] active_div
);

  localparam logic [W-1:0] DEF_DIV = DEFAULT_DIV[W-1:0];
  localparam logic [W-1:0] ONE     = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] TWO     = {{(W-2){1'b0}}, 2'b10};

  typedef enum logic {IDLE, RUN} state_t;

  state_t       state;
  logic [W-1:0] phase;
  logic [W-1:0] pending;

  logic         wrap;
  logic         boundary;
  logic         apply;
  logic         load_ok;
  logic         load_bad;
  logic [W-1:0] phase_next;
  logic [W:0]   hi;

  // Next-phase, high-length and period-boundary decode for the running divider
  always_comb begin
    wrap       = (state == RUN) && (phase == active_div - ONE);
    phase_next = wrap ? '0 : phase + ONE;
    // W+1 bits so that N = 2^W-1 cannot overflow the (N+1)>>1 computation
    hi         = ({1'b0, active_div} + {{W{1'b0}}, 1'b1}) >> 1;
    boundary   = enable && ((state == IDLE) || wrap);
    apply      = boundary && div_pending;
    load_ok    = div_load && (div_val >= TWO);
    load_bad   = div_load && (div_val < TWO);
  end

  // Pending divisor holding register; only meaningful while div_pending is set
  always_ff @(posedge clk) begin
    if (load_ok) begin
      pending <= div_val;
    end
  end

  // Divider state machine, divisor bookkeeping and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      phase       <= '0;
      clk_div     <= 1'b0;
      tick        <= 1'b0;
      div_pending <= 1'b0;
      div_err     <= 1'b0;
      active_div  <= DEF_DIV;
    end else begin
      div_err <= load_bad;

      // A load in the boundary cycle itself re-arms pending after the old one applies
      if (apply) begin
        active_div <= pending;
      end
      if (load_ok) begin
        div_pending <= 1'b1;
      end else if (apply) begin
        div_pending <= 1'b0;
      end

      case (state)
        IDLE: begin
          phase <= '0;
          if (enable) begin
            state   <= RUN;
            clk_div <= 1'b1;
            tick    <= 1'b1;
          end else begin
            clk_div <= 1'b0;
            tick    <= 1'b0;
          end
        end
        RUN: begin
          if (enable) begin
            phase   <= phase_next;
            // phase_next==0 at the wrap is always high, so the new HI is never needed here
            clk_div <= ({1'b0, phase_next} < hi);
            tick    <= (phase_next == '0);
          end else begin
            // Abandon the current period immediately; a pending divisor survives
            state   <= IDLE;
            phase   <= '0;
            clk_div <= 1'b0;
            tick    <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          phase   <= '0;
          clk_div <= 1'b0;
          tick    <= 1'b0;
        end
      endcase
    end
  end

endmodule
